// File: rtl/jpeg_ring_bridge_if.sv
// Bundle of the ring, jpeg_core and status signals of jpeg_ring_bridge.
// slave  : the bridge side.
// master : the side driving the bridge (SoC glue or bench).
// Counter outputs exist only when JPEG_RING_BRIDGE_STATS_EN is defined.
interface jpeg_ring_bridge_if #(
    parameter int unsigned ring_width_p  = 88,
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned strb_width_p  = data_width_p / 8,
    parameter int unsigned dim_width_p   = 16,
    parameter int unsigned color_width_p = 8
) ();

    // ring ingress
    logic                     ring_v_i;
    logic [ring_width_p-1:0]  ring_data_i;
    logic                     ring_yumi_o;

    // beats to jpeg_core
    logic                     core_valid_o;
    logic [data_width_p-1:0]  core_data_o;
    logic [strb_width_p-1:0]  core_strb_o;
    logic                     core_last_o;
    logic                     core_accept_i;

    // pixels from jpeg_core
    logic                     pix_valid_i;
    logic [dim_width_p-1:0]   pix_width_i;
    logic [dim_width_p-1:0]   pix_height_i;
    logic [dim_width_p-1:0]   pix_x_i;
    logic [dim_width_p-1:0]   pix_y_i;
    logic [color_width_p-1:0] pix_r_i;
    logic [color_width_p-1:0] pix_g_i;
    logic [color_width_p-1:0] pix_b_i;
    logic                     pix_accept_o;

    // ring egress
    logic                     ring_v_o;
    logic [ring_width_p-1:0]  ring_data_o;
    logic                     ring_ready_i;

    // status
    logic                     frame_done_o;
    logic                     idle_o;

`ifdef JPEG_RING_BRIDGE_STATS_EN
    logic [31:0]              pix_count_o;
    logic [31:0]              stall_count_o;
    logic [31:0]              beat_count_o;
`endif

    modport slave (
`ifdef JPEG_RING_BRIDGE_STATS_EN
        output pix_count_o, stall_count_o, beat_count_o,
`endif
        input  ring_v_i, ring_data_i,
        output ring_yumi_o,
        output core_valid_o, core_data_o, core_strb_o, core_last_o,
        input  core_accept_i,
        input  pix_valid_i, pix_width_i, pix_height_i, pix_x_i, pix_y_i,
        input  pix_r_i, pix_g_i, pix_b_i,
        output pix_accept_o,
        output ring_v_o, ring_data_o,
        input  ring_ready_i,
        output frame_done_o, idle_o
    );

    modport master (
`ifdef JPEG_RING_BRIDGE_STATS_EN
        input  pix_count_o, stall_count_o, beat_count_o,
`endif
        output ring_v_i, ring_data_i,
        input  ring_yumi_o,
        input  core_valid_o, core_data_o, core_strb_o, core_last_o,
        output core_accept_i,
        output pix_valid_i, pix_width_i, pix_height_i, pix_x_i, pix_y_i,
        output pix_r_i, pix_g_i, pix_b_i,
        input  pix_accept_o,
        input  ring_v_o, ring_data_o,
        output ring_ready_i,
        input  frame_done_o, idle_o
    );

endinterface

// File: rtl/jpeg_ring_bridge.sv
// Bridge between an fsb-style ring port and the jpeg_core stream interfaces.
//   ingress: ring word -> one-entry slice -> data/strobe/last beat
//   egress : pixel fields -> els_p-deep FIFO -> packed ring word
// Also reports end-of-frame and idle.
// Optional JPEG_RING_BRIDGE_STATS_EN adds pixel/stall/beat counters.
module jpeg_ring_bridge #(
    parameter int unsigned ring_width_p  = 88,
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned strb_width_p  = data_width_p / 8,
    parameter int unsigned els_p         = 4,
    parameter int unsigned dim_width_p   = 16,
    parameter int unsigned color_width_p = 8
) (
    input logic            clk_i,
    input logic            rst_i,
    jpeg_ring_bridge_if.slave bus
);

    localparam int unsigned pack_w = 4 * dim_width_p + 3 * color_width_p;
    localparam int unsigned ptr_w  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w  = $clog2(els_p + 1);

    localparam logic [ptr_w-1:0] last_ptr   = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_count = cnt_w'(els_p);

    // ------------------------------------------------------------------
    // Ingress slice
    // ------------------------------------------------------------------
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slice_state_t;

    slice_state_t            state;
    logic                    core_valid;
    logic [data_width_p-1:0] core_data;
    logic [strb_width_p-1:0] core_strb;
    logic                    core_last;
    logic                    yumi;
    logic                    unused_ring_bits;

    // bits between strobe and data carry nothing
    assign unused_ring_bits = ^bus.ring_data_i;

    assign yumi = bus.ring_v_i & ((state == EMPTY) | bus.core_accept_i);

    // slice FSM: load on yumi (reload when draining), empty on bare accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= EMPTY;
            core_valid <= 1'b0;
            core_data  <= '0;
            core_strb  <= '0;
            core_last  <= 1'b0;
        end else if (yumi) begin
            state      <= FULL;
            core_valid <= 1'b1;
            core_last  <= bus.ring_data_i[ring_width_p-1];
            core_strb  <= bus.ring_data_i[ring_width_p-2 -: strb_width_p];
            core_data  <= bus.ring_data_i[data_width_p-1:0];
        end else if (bus.core_accept_i) begin
            state      <= EMPTY;
            core_valid <= 1'b0;
        end
    end

    assign bus.ring_yumi_o  = yumi;
    assign bus.core_valid_o = core_valid;
    assign bus.core_data_o  = core_data;
    assign bus.core_strb_o  = core_strb;
    assign bus.core_last_o  = core_last;

    // ------------------------------------------------------------------
    // Egress FIFO
    // ------------------------------------------------------------------
    logic [ring_width_p-1:0] storage [els_p];
    logic [ptr_w-1:0]        wr_ptr;
    logic [ptr_w-1:0]        rd_ptr;
    logic [cnt_w-1:0]        count;
    logic                    pix_accept;
    logic                    fifo_v;
    logic                    push;
    logic                    pop;
    logic [ring_width_p-1:0] packed_word;
    logic [dim_width_p-1:0]  last_x;
    logic [dim_width_p-1:0]  last_y;
    logic                    frame_done;

    assign pix_accept = (count != full_count);
    assign fifo_v     = (count != '0);
    assign push       = bus.pix_valid_i & pix_accept;
    assign pop        = fifo_v & bus.ring_ready_i;

    // pack pixel fields MSB-first, b in the LSBs, upper bits zero
    always_comb begin
        packed_word = '0;
        packed_word[pack_w-1:0] = {bus.pix_width_i, bus.pix_height_i,
                                   bus.pix_x_i, bus.pix_y_i,
                                   bus.pix_r_i, bus.pix_g_i, bus.pix_b_i};
    end

    // storage write; contents need no reset since reads are gated by count
    always_ff @(posedge clk_i) begin
        if (push) begin
            storage[wr_ptr] <= packed_word;
        end
    end

    // pointers wrap at els_p-1 so non-power-of-two depths work
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.pix_accept_o = pix_accept;
    assign bus.ring_v_o     = fifo_v;
    assign bus.ring_data_o  = fifo_v ? storage[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Frame completion and idle
    // ------------------------------------------------------------------
    assign last_x = bus.pix_width_i  - dim_width_p'(1);
    assign last_y = bus.pix_height_i - dim_width_p'(1);

    // one-cycle pulse after the push of the last pixel of a frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= push & (bus.pix_x_i == last_x) & (bus.pix_y_i == last_y);
        end
    end

    assign bus.frame_done_o = frame_done;
    assign bus.idle_o       = (state == EMPTY) & (count == '0);

`ifdef JPEG_RING_BRIDGE_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters, free-running and wrapping at 2^32
    // ------------------------------------------------------------------
    logic [31:0] pix_count;
    logic [31:0] stall_count;
    logic [31:0] beat_count;

    // count pushes, refused pixel cycles and accepted core beats
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_count   <= '0;
            stall_count <= '0;
            beat_count  <= '0;
        end else begin
            if (push) begin
                pix_count <= pix_count + 32'd1;
            end
            if (bus.pix_valid_i & ~pix_accept) begin
                stall_count <= stall_count + 32'd1;
            end
            if (core_valid & bus.core_accept_i) begin
                beat_count <= beat_count + 32'd1;
            end
        end
    end

    assign bus.pix_count_o   = pix_count;
    assign bus.stall_count_o = stall_count;
    assign bus.beat_count_o  = beat_count;
`endif

endmodule

// File: tb/tb_jpeg_ring_bridge.sv
// Directed bench for jpeg_ring_bridge (default parameters, els_p = 4).
// Counter checks are compiled in with JPEG_RING_BRIDGE_STATS_EN.
module tb_jpeg_ring_bridge;

    localparam int unsigned RW = 88;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned EL = 4;
    localparam int unsigned DM = 16;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst;

    jpeg_ring_bridge_if #(
        .ring_width_p (RW),
        .data_width_p (DW),
        .strb_width_p (SW),
        .dim_width_p  (DM),
        .color_width_p(CW)
    ) bus ();

    jpeg_ring_bridge #(
        .ring_width_p (RW),
        .data_width_p (DW),
        .strb_width_p (SW),
        .els_p        (EL),
        .dim_width_p  (DM),
        .color_width_p(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic        acc;
        logic        exp_yumi;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic        exp_last;
    } in_vec_t;

    typedef struct {
        logic [15:0] w, h, x, y;
        logic [7:0]  r, g, b;
        logic [87:0] exp_data;
        logic        exp_fd;
    } pix_vec_t;

    in_vec_t  iv[7];
    pix_vec_t pv[6];

    logic [87:0] q[$];
    logic [87:0] exp_w;
    int sent, recv, cyc;
    int exp_pix, exp_stall, exp_beat;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [87:0] mk_ring(input logic l, input logic [3:0] s, input logic [31:0] d);
        logic [87:0] r;
        r = '0;
        r[87] = l;
        r[86 -: 4] = s;
        r[31:0] = d;
        return r;
    endfunction

    function automatic logic [87:0] pk(input logic [15:0] w, h, x, y, input logic [7:0] r, g, b);
        return {w, h, x, y, r, g, b};
    endfunction

    task automatic drive_pix(input logic [15:0] w, h, x, y, input logic [7:0] r, g, b);
        bus.pix_width_i  = w;
        bus.pix_height_i = h;
        bus.pix_x_i      = x;
        bus.pix_y_i      = y;
        bus.pix_r_i      = r;
        bus.pix_g_i      = g;
        bus.pix_b_i      = b;
    endtask

    initial begin
        // ingress table: cycle by cycle, accept pattern on beats 1,0,1,1,1
        iv[0] = '{1'b1, 32'h1111_0000, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         4'h0, 1'b0};
        iv[1] = '{1'b1, 32'h2222_0001, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_0000, 4'h1, 1'b0};
        iv[2] = '{1'b1, 32'h3333_0002, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_0001, 4'h3, 1'b0};
        iv[3] = '{1'b1, 32'h3333_0002, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2222_0001, 4'h3, 1'b0};
        iv[4] = '{1'b1, 32'h4444_0003, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3333_0002, 4'h7, 1'b0};
        iv[5] = '{1'b0, 32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4444_0003, 4'hF, 1'b1};
        iv[6] = '{1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'h0, 1'b0};

        // packing / frame-end table
        pv[0] = '{16'h0008, 16'h0008, 16'h0007, 16'h0007, 8'h12, 8'h34, 8'h56,
                  88'h0008_0008_0007_0007_123456, 1'b1};
        pv[1] = '{16'h0008, 16'h0008, 16'h0006, 16'h0007, 8'hAA, 8'hBB, 8'hCC,
                  88'h0008_0008_0006_0007_AABBCC, 1'b0};
        pv[2] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 8'h01, 8'h02, 8'h03,
                  88'h0000_0000_FFFF_FFFF_010203, 1'b1};
        pv[3] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 8'hFF, 8'h00, 8'hFF,
                  88'h0001_0001_0000_0000_FF00FF, 1'b1};
        pv[4] = '{16'h0280, 16'h01E0, 16'h027F, 16'h01DE, 8'h10, 8'h20, 8'h30,
                  88'h0280_01E0_027F_01DE_102030, 1'b0};
        pv[5] = '{16'h0280, 16'h01E0, 16'h027F, 16'h01DF, 8'h40, 8'h50, 8'h60,
                  88'h0280_01E0_027F_01DF_405060, 1'b1};

        exp_pix = 0; exp_stall = 0; exp_beat = 0;

        rst = 1'b1;
        bus.ring_v_i = 1'b0;
        bus.ring_data_i = '0;
        bus.core_accept_i = 1'b0;
        bus.pix_valid_i = 1'b0;
        drive_pix(16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
        bus.ring_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_core_valid", bus.core_valid_o, 1'b0);
        chk("rst_ring_v",     bus.ring_v_o, 1'b0);
        chk("rst_idle",       bus.idle_o, 1'b1);
        chk("rst_pix_accept", bus.pix_accept_o, 1'b1);
        chk("rst_frame_done", bus.frame_done_o, 1'b0);
        chk("rst_yumi",       bus.ring_yumi_o, 1'b0);

        // single beat with accept held high
        step();
        bus.ring_v_i = 1'b1;
        bus.ring_data_i = mk_ring(1'b1, 4'hF, 32'hDEADBEEF);
        bus.core_accept_i = 1'b1;
        #1;
        chk("t1_yumi", bus.ring_yumi_o, 1'b1);
        chk("t1_valid_before", bus.core_valid_o, 1'b0);
        step();
        bus.ring_v_i = 1'b0;
        #1;
        chk("t1_valid", bus.core_valid_o, 1'b1);
        chk("t1_data",  bus.core_data_o, 32'hDEADBEEF);
        chk("t1_strb",  bus.core_strb_o, 4'hF);
        chk("t1_last",  bus.core_last_o, 1'b1);
        chk("t1_busy",  bus.idle_o, 1'b0);
        exp_beat++;
        step();
        chk("t1_idle",  bus.idle_o, 1'b1);
        chk("t1_valid_after", bus.core_valid_o, 1'b0);

        // back-to-back beats with one stalled cycle
        for (int i = 0; i < 7; i++) begin
            bus.ring_v_i = iv[i].v;
            bus.ring_data_i = mk_ring(iv[i].l, iv[i].s, iv[i].d);
            bus.core_accept_i = iv[i].acc;
            #1;
            chk($sformatf("t2_yumi_%0d", i), bus.ring_yumi_o, iv[i].exp_yumi);
            chk($sformatf("t2_valid_%0d", i), bus.core_valid_o, iv[i].exp_valid);
            if (iv[i].exp_valid) begin
                chk($sformatf("t2_data_%0d", i), bus.core_data_o, iv[i].exp_data);
                chk($sformatf("t2_strb_%0d", i), bus.core_strb_o, iv[i].exp_strb);
                chk($sformatf("t2_last_%0d", i), bus.core_last_o, iv[i].exp_last);
            end
            if (iv[i].exp_valid && iv[i].acc) exp_beat++;
            step();
        end
        bus.core_accept_i = 1'b0;
        chk("t2_idle", bus.idle_o, 1'b1);

        // fill FIFO with ring_ready low, fifth pixel held
        for (int k = 0; k < 4; k++) begin
            bus.pix_valid_i = 1'b1;
            drive_pix(16'd8, 16'd8, 16'(k), 16'd0, 8'(k), 8'hC0, 8'h0F);
            #1;
            chk($sformatf("t3_accept_%0d", k), bus.pix_accept_o, 1'b1);
            exp_pix++;
            step();
        end
        drive_pix(16'd8, 16'd8, 16'd4, 16'd0, 8'd4, 8'hC0, 8'h0F);
        #1;
        chk("t3_full_accept", bus.pix_accept_o, 1'b0);
        chk("t3_full_v", bus.ring_v_o, 1'b1);
        chk("t3_head", bus.ring_data_o, pk(16'd8, 16'd8, 16'd0, 16'd0, 8'd0, 8'hC0, 8'h0F));
        exp_stall++;
        step();
        chk("t3_held_accept", bus.pix_accept_o, 1'b0);
        bus.ring_ready_i = 1'b1;
        #1;
        chk("t3_pop0", bus.ring_data_o, pk(16'd8, 16'd8, 16'd0, 16'd0, 8'd0, 8'hC0, 8'h0F));
        exp_stall++;
        step();
        chk("t3_reopen", bus.pix_accept_o, 1'b1);
        chk("t3_pop1", bus.ring_data_o, pk(16'd8, 16'd8, 16'd1, 16'd0, 8'd1, 8'hC0, 8'h0F));
        exp_pix++;
        step();
        bus.pix_valid_i = 1'b0;
        for (int j = 2; j < 5; j++) begin
            #1;
            chk($sformatf("t3_v_%0d", j), bus.ring_v_o, 1'b1);
            chk($sformatf("t3_pop%0d", j), bus.ring_data_o,
                pk(16'd8, 16'd8, 16'(j), 16'd0, 8'(j), 8'hC0, 8'h0F));
            step();
        end
        bus.ring_ready_i = 1'b0;
        #1;
        chk("t3_drained", bus.ring_v_o, 1'b0);
        chk("t3_idle", bus.idle_o, 1'b1);

        // packing and frame-end pulse
        for (int i = 0; i < 6; i++) begin
            step();
            bus.pix_valid_i = 1'b1;
            drive_pix(pv[i].w, pv[i].h, pv[i].x, pv[i].y, pv[i].r, pv[i].g, pv[i].b);
            exp_pix++;
            step();
            bus.pix_valid_i = 1'b0;
            bus.ring_ready_i = 1'b1;
            #1;
            chk($sformatf("t4_v_%0d", i), bus.ring_v_o, 1'b1);
            chk($sformatf("t4_data_%0d", i), bus.ring_data_o, pv[i].exp_data);
            chk($sformatf("t4_fd_%0d", i), bus.frame_done_o, pv[i].exp_fd);
            step();
            chk($sformatf("t4_fd_off_%0d", i), bus.frame_done_o, 1'b0);
            chk($sformatf("t4_empty_%0d", i), bus.ring_v_o, 1'b0);
            bus.ring_ready_i = 1'b0;
        end

        // pointer wrap: 10 pixels, ring_ready alternating
        step();
        sent = 0; recv = 0; cyc = 0;
        q.delete();
        while (recv < 10 && cyc < 100) begin
            bus.pix_valid_i = (sent < 10);
            drive_pix(16'd16, 16'd16, 16'(sent), 16'd0, 8'(8'h40 + sent), 8'h55, 8'(sent));
            bus.ring_ready_i = (cyc % 2 == 0);
            #1;
            chk("t5_accept", bus.pix_accept_o, (q.size() != EL));
            chk("t5_v", bus.ring_v_o, (q.size() != 0));
            if (bus.pix_valid_i && q.size() == EL) exp_stall++;
            if (bus.ring_v_o && bus.ring_ready_i && q.size() != 0) begin
                exp_w = q.pop_front();
                chk($sformatf("t5_data_%0d", recv), bus.ring_data_o, exp_w);
                recv++;
            end
            if (bus.pix_valid_i && bus.pix_accept_o) begin
                q.push_back(pk(16'd16, 16'd16, 16'(sent), 16'd0, 8'(8'h40 + sent), 8'h55, 8'(sent)));
                sent++;
                exp_pix++;
            end
            cyc++;
            step();
        end
        chk("t5_all_received", 32'(recv), 32'd10);
        bus.pix_valid_i = 1'b0;
        bus.ring_ready_i = 1'b0;

        // reset with a full slice and three FIFO entries
        bus.ring_v_i = 1'b1;
        bus.ring_data_i = mk_ring(1'b0, 4'h5, 32'hCAFE_F00D);
        bus.core_accept_i = 1'b0;
        step();
        bus.ring_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.pix_valid_i = 1'b1;
            drive_pix(16'd4, 16'd4, 16'(k), 16'd0, 8'h77, 8'h88, 8'(k));
            exp_pix++;
            step();
        end
        bus.pix_valid_i = 1'b0;
        #1;
        chk("t6_pre_valid", bus.core_valid_o, 1'b1);
        chk("t6_pre_ring_v", bus.ring_v_o, 1'b1);
        chk("t6_pre_idle", bus.idle_o, 1'b0);
`ifdef JPEG_RING_BRIDGE_STATS_EN
        chk("t6_pix_count", bus.pix_count_o, 32'(exp_pix));
        chk("t6_stall_count", bus.stall_count_o, 32'(exp_stall));
        chk("t6_beat_count", bus.beat_count_o, 32'(exp_beat));
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_core_valid", bus.core_valid_o, 1'b0);
        chk("t6_ring_v", bus.ring_v_o, 1'b0);
        chk("t6_idle", bus.idle_o, 1'b1);
        chk("t6_pix_accept", bus.pix_accept_o, 1'b1);
        chk("t6_yumi", bus.ring_yumi_o, 1'b0);
        chk("t6_ring_data", bus.ring_data_o, 88'h0);
`ifdef JPEG_RING_BRIDGE_STATS_EN
        chk("t6_pix_count_rst", bus.pix_count_o, 32'd0);
        chk("t6_stall_count_rst", bus.stall_count_o, 32'd0);
        chk("t6_beat_count_rst", bus.beat_count_o, 32'd0);
`endif
        step();
        chk("t6_still_empty", bus.ring_v_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule
